// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel-load / serial-out handshake bundle between a word
// source (master) and the serializer (slave).
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic             ovr;

    modport master (
        output din, load,
        input  ready, x, x_valid, done, ovr
    );

    modport slave (
        input  din, load,
        output ready, x, x_valid, done, ovr
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: Moore FSM that loads a WIDTH-bit word and shifts it out one bit per
// clock, accepting the next word on the last-bit cycle so streams have no gap.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt, w_sr_shift;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_ovr;
    logic             w_last;

    assign w_last      = (r_state == SHIFT) && (r_cnt == LAST);
    assign w_sr_shift  = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
    assign bus.ready   = (r_state == IDLE) || w_last;
    assign bus.done    = w_last;
    assign bus.x_valid = (r_state == SHIFT);
    assign bus.x       = (r_state == SHIFT) && (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]);
    assign bus.ovr     = r_ovr;

    // An out-of-range cnt or unknown state encoding falls through to IDLE.
    always_comb begin
        w_state_nxt = IDLE;
        w_sr_nxt    = '0;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_state_nxt = bus.load ? SHIFT : IDLE;
                w_sr_nxt    = bus.load ? bus.din : r_sr;
            end
            SHIFT: begin
                if (r_cnt < LAST) begin
                    w_state_nxt = SHIFT;
                    w_sr_nxt    = w_sr_shift;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end else if (w_last && bus.load) begin
                    w_state_nxt = SHIFT;
                    w_sr_nxt    = bus.din;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            if (bus.load && !bus.ready) r_ovr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench; stimulus pushes expected serial bits, a
// negedge monitor pops and compares them against both MSB- and LSB-first instances.
module tb_piso_serializer;
    typedef struct packed {logic x; logic done;} exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    int   max_run = 0;
    int   bitpos = 0;
    logic [3:0]  det = '0;
    logic [31:0] det_mask = '0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) b0 ();
    piso_serializer_if #(.WIDTH(8)) b1 ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // seq holds the bits in transmit order, first bit in seq[7]
    task automatic push(input int id, input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) begin
            if (id == 0) q0.push_back('{seq[i], i == 0});
            else q1.push_back('{seq[i], i == 0});
        end
    endtask

    task automatic mon(input int id, input logic v, input logic x, input logic d);
        exp_t e;
        if (!v) begin
            chk($sformatf("idle_out%0d", id), 32'({x, d}), 32'd0);
            return;
        end
        if ((id == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit%0d: got x_valid=1 expected no pending bit", id);
            return;
        end
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("bit%0d_x", id), 32'(x), 32'(e.x));
        chk($sformatf("bit%0d_done", id), 32'(d), 32'(e.done));
    endtask

    always @(negedge clk) begin
        mon(0, b0.x_valid, b0.x, b0.done);
        mon(1, b1.x_valid, b1.x, b1.done);
        run = b0.x_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (b0.x_valid) begin
            det = {det[2:0], b0.x};
            bitpos++;
            if (det == 4'b1010 && bitpos <= 32) det_mask[bitpos-1] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        b0.load = 1'b0; b0.din = '0;
        b1.load = 1'b0; b1.din = '0;
        #1;
        chk("rst_ready", 32'(b0.ready), 32'd1);
        chk("rst_x", 32'(b0.x), 32'd0);
        chk("rst_xv", 32'(b0.x_valid), 32'd0);
        chk("rst_done", 32'(b0.done), 32'd0);
        chk("rst_ovr", 32'(b0.ovr), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        // AA msb-first and 0A lsb-first, accepted on the first edge after release
        b0.din = 8'hAA; b0.load = 1'b1; push(0, 8'b10101010);
        b1.din = 8'h0A; b1.load = 1'b1; push(1, 8'b01010000);
        tick();
        b0.load = 1'b0; b1.load = 1'b0;
        b0.din = 8'($urandom); b1.din = 8'($urandom);
        repeat (8) tick();
        chk("aa_idle_ready", 32'(b0.ready), 32'd1);
        chk("aa_idle_xv", 32'(b0.x_valid), 32'd0);
        chk("0a_idle_ready", 32'(b1.ready), 32'd1);
        // back-to-back A5 then 3C loaded while done=1
        max_run = 0;
        b0.din = 8'hA5; b0.load = 1'b1; push(0, 8'b10100101);
        tick();
        b0.load = 1'b0;
        repeat (7) tick();
        chk("b2b_done", 32'(b0.done), 32'd1);
        chk("b2b_ready", 32'(b0.ready), 32'd1);
        b0.din = 8'h3C; b0.load = 1'b1; push(0, 8'b00111100);
        tick();
        b0.load = 1'b0;
        repeat (8) tick();
        chk("b2b_run", 32'(max_run), 32'd16);
        chk("b2b_idle_xv", 32'(b0.x_valid), 32'd0);
        // overrun load at edge 3
        chk("ovr_before", 32'(b0.ovr), 32'd0);
        b0.din = 8'hAA; b0.load = 1'b1; push(0, 8'b10101010);
        tick();
        b0.load = 1'b0;
        repeat (2) tick();
        chk("ovr_busy_ready", 32'(b0.ready), 32'd0);
        b0.din = 8'hFF; b0.load = 1'b1;
        tick();
        b0.load = 1'b0;
        chk("ovr_set", 32'(b0.ovr), 32'd1);
        repeat (5) tick();
        chk("ovr_held", 32'(b0.ovr), 32'd1);
        chk("ovr_idle_xv", 32'(b0.x_valid), 32'd0);
        // asynchronous reset during bit 4
        b0.din = 8'h5A; b0.load = 1'b1; push(0, 8'b01011010);
        tick();
        b0.load = 1'b0;
        repeat (3) tick();
        chk("mid_xv", 32'(b0.x_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_x", 32'(b0.x), 32'd0);
        chk("arst_xv", 32'(b0.x_valid), 32'd0);
        chk("arst_ready", 32'(b0.ready), 32'd1);
        chk("arst_done", 32'(b0.done), 32'd0);
        chk("arst_ovr", 32'(b0.ovr), 32'd0);
        q0.delete();
        tick();
        rst = 1'b1;
        b0.din = 8'hFF; b0.load = 1'b1; push(0, 8'b11111111);
        tick();
        b0.load = 1'b0;
        repeat (8) tick();
        chk("ff_idle_xv", 32'(b0.x_valid), 32'd0);
        chk("ff_ovr", 32'(b0.ovr), 32'd0);
        // 1,0,1,0,1,0,0,0 into an overlapping 1010 detector
        det = '0; bitpos = 0; det_mask = '0;
        b0.din = 8'hA8; b0.load = 1'b1; push(0, 8'b10101000);
        tick();
        b0.load = 1'b0;
        repeat (8) tick();
        chk("det_positions", det_mask, 32'h28);
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) tick();
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, shall set the parallel word width; legal range is 2 to 32.
REQ-002 Parameter MSB_FIRST, default 1, shall select the transmit order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  shall be the asynchronous, active-low reset.
REQ-005 din  input  WIDTH  shall be the parallel word, sampled only on an accepted load.
REQ-006 load  input  1  shall be the load request; accepted only when load=1 and ready=1 at a rising clk edge.
REQ-007 ready  output  1  shall indicate that a load is accepted on the current edge.
REQ-008 x  output  1  shall be the serial bit stream, one bit per clk, for the downstream sequence detector.
REQ-009 x_valid  output  1  shall be high in every cycle in which x carries a data bit.
REQ-010 done  output  1  shall be a one-cycle pulse that marks the last bit of a word.
REQ-011 ovr  output  1  shall be a sticky flag that marks a load request made while ready=0.

Function
REQ-012 The block shall be a Moore FSM with two states: IDLE and SHIFT, with a WIDTH-bit shift register sr and a bit counter cnt of $clog2(WIDTH) bits.
REQ-013 All outputs shall be decoded from registered state only; there shall be no combinational path from din or load to any output.
REQ-014 IDLE outputs: ready=1, x=0, x_valid=0, done=0.
REQ-015 SHIFT outputs: x_valid=1; x=sr[WIDTH-1] when MSB_FIRST=1, x=sr[0] when MSB_FIRST=0; ready=done=(cnt==WIDTH-1).
REQ-016 IDLE -> SHIFT shall occur on an accepted load, with sr<=din and cnt<=0.
REQ-017 First-bit latency shall be exactly one cycle: the first bit of the word appears on x in the cycle after the acceptance edge.
REQ-018 In SHIFT with cnt<WIDTH-1, each edge shall shift sr by one toward the output end, zero-fill the vacated bit, and increment cnt.
REQ-019 In SHIFT with cnt==WIDTH-1 and load=1, the block shall stay in SHIFT with sr<=din and cnt<=0, so back-to-back words stream with no gap bit.
REQ-020 In SHIFT with cnt==WIDTH-1 and load=0, the next state shall be IDLE.
REQ-021 x_valid shall be high for exactly WIDTH consecutive cycles per accepted word.
REQ-022 A load=1 while ready=0 shall be ignored (sr and cnt unchanged) and shall set ovr<=1.
REQ-023 ovr shall clear only on reset.
REQ-024 din shall be don't-care in every cycle without an accepted load.
REQ-025 cnt shall never exceed WIDTH-1; illegal state encodings shall return to IDLE on the next edge.

Reset
REQ-026 rst=0 shall immediately, without waiting for clk, force state=IDLE, sr=0, cnt=0, ovr=0, giving outputs ready=1, x=0, x_valid=0, done=0.
REQ-027 Reset asserted mid-word shall discard the remaining bits; after release the block shall accept a load on the first edge.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, din=8'hAA accepted at edge 0 -> x=1,0,1,0,1,0,1,0 in cycles 1-8, x_valid=1 in cycles 1-8, done=1 in cycle 8 only, then IDLE.
REQ-029 MSB_FIRST=0, din=8'h0A -> x=0,1,0,1,0,0,0,0 in cycles 1-8.
REQ-030 din=8'hA5 loaded at edge 0 and din=8'h3C loaded at edge 8 (while done=1) -> 16 contiguous x_valid cycles with bits A5 then 3C, and no gap cycle.
REQ-031 load=1 at edge 3 of a word in progress -> word is unaffected, ovr=1 from cycle 4 and held until reset.
REQ-032 rst=0 asserted asynchronously during bit 4 -> x=0, x_valid=0, ready=1 immediately; after release, din=8'hFF loaded -> eight 1 bits are output.
REQ-033 Serialize the stream 1,0,1,0,1,0 into the downstream 1010 detector -> detect pulses occur at the 4th and 6th bit positions (overlapping detection).
